// File: rtl/seg7_pkg.sv
// Shared types and segment glyphs for the multiplexed 7-segment driver.
// Segment order is a..g on bits 6..0; all patterns are active-low (0 = lit).
// Glyph constants are pure data; decoding lives in seg7_hex_decode.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t GLYPH_0 = 7'h01;
  localparam seg_t GLYPH_1 = 7'h4F;
  localparam seg_t GLYPH_2 = 7'h12;
  localparam seg_t GLYPH_3 = 7'h06;
  localparam seg_t GLYPH_4 = 7'h4C;
  localparam seg_t GLYPH_5 = 7'h24;
  localparam seg_t GLYPH_6 = 7'h20;
  localparam seg_t GLYPH_7 = 7'h0F;
  localparam seg_t GLYPH_8 = 7'h00;
  localparam seg_t GLYPH_9 = 7'h04;
  localparam seg_t GLYPH_A = 7'h08;
  localparam seg_t GLYPH_B = 7'h60;
  localparam seg_t GLYPH_C = 7'h31;
  localparam seg_t GLYPH_D = 7'h42;
  localparam seg_t GLYPH_E = 7'h30;
  localparam seg_t GLYPH_F = 7'h38;

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low segment pattern decoder.
// Latency: combinational.
// Codes 10-15 show A,b,C,d,E,F when hex_en is set, otherwise blank.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  output seg_t       seg
);

  // Glyph lookup; letters are gated by hex_en so decimal-only builds show blank.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = hex_en ? GLYPH_A : SEG_BLANK;
      4'hB: seg = hex_en ? GLYPH_B : SEG_BLANK;
      4'hC: seg = hex_en ? GLYPH_C : SEG_BLANK;
      4'hD: seg = hex_en ? GLYPH_D : SEG_BLANK;
      4'hE: seg = hex_en ? GLYPH_E : SEG_BLANK;
      4'hF: seg = hex_en ? GLYPH_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a tear-free frame buffer.
// Latency: seg/dp/an/frame_tick are registered, one cycle behind the scan counters.
// No backpressure: free-running scan; load is a single-cycle strobe always accepted.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 100000,
  parameter int BRIGHT_W = 3,
  parameter int HEX_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] din,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  load,
  input  logic                  lzb_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output seg_t                  seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SUB_LEN = SCAN_DIV >> BRIGHT_W;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_end;
  logic                  frame_wrap;

  logic [4*N_DIGITS-1:0] pend_code;
  logic [N_DIGITS-1:0]   pend_dp;
  logic [4*N_DIGITS-1:0] act_code;
  logic [N_DIGITS-1:0]   act_dp;

  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_en;
  logic [N_DIGITS-1:0]   lead_zero;
  logic                  lzb_blank;
  logic                  digit_blank;
  seg_t                  dec_seg;

  logic [31:0]           sub_idx;
  logic                  pwm_on;
  logic                  guard;

  assign slot_end   = (div_cnt == DIV_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  // Slot divider and digit index: one digit per SCAN_DIV cycles, wrapping to digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Double buffer: loads land in pending; active only changes at a frame wrap,
  // taking din directly when the load coincides with the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_code <= '0;
      pend_dp   <= '0;
      act_code  <= '0;
      act_dp    <= '0;
    end else begin
      if (load) begin
        pend_code <= din;
        pend_dp   <= dp_in;
      end
      if (frame_wrap) begin
        act_code <= load ? din   : pend_code;
        act_dp   <= load ? dp_in : pend_dp;
      end
    end
  end

  // Leading-zero flags: digit i qualifies when it and every digit to its left are zero.
  always_comb begin
    lead_zero = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      lead_zero[i] = 1'b1;
      for (int j = i; j < N_DIGITS; j++) begin
        if (act_code[4*j +: 4] != 4'd0) begin
          lead_zero[i] = 1'b0;
        end
      end
    end
  end

  assign cur_code    = act_code[4*int'(idx) +: 4];
  assign cur_dp      = act_dp[idx];
  assign cur_en      = digit_en[idx];
  assign lzb_blank   = lzb_en && (idx != '0) && lead_zero[idx];
  assign digit_blank = !cur_en || lzb_blank;

  seg7_hex_decode u_decode (
    .code   (cur_code),
    .hex_en (HEX_EN != 0),
    .seg    (dec_seg)
  );

  // PWM: the slot is split into 2**BRIGHT_W sub-slots; sub-slots 0..bright are lit.
  assign sub_idx = 32'(div_cnt) / 32'(SUB_LEN);
  assign pwm_on  = (sub_idx <= 32'(bright));

  // First cycle of every slot (index just moved) keeps all anodes off to avoid ghosting.
  assign guard = (div_cnt == '0);

  // Output registers: blanked digits still scan their anode, only segments go dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= digit_blank ? SEG_BLANK : dec_seg;
      dp         <= digit_blank | ~cur_dp;
      an         <= (guard || !pwm_on) ? '1 : ~(N_DIGITS'(1) << idx);
      frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-bit brightness).
// A cycle-count reference model pushes the expected pins for each clock edge;
// a monitor pops one entry after every edge and compares both DUT instances.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BW = 2;
  localparam int L  = SD >> BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*N-1:0] din = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  digit_en = '1;
  logic          load = 1'b0;
  logic          lzb_en = 1'b0;
  logic [BW-1:0] bright = '1;

  logic [6:0]    seg, seg_nh;
  logic          dp, dp_nh;
  logic [N-1:0]  an, an_nh;
  logic          frame_tick, ft_nh;

  seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BRIGHT_W(BW), .HEX_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .lzb_en(lzb_en), .bright(bright),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BRIGHT_W(BW), .HEX_EN(0)) u_dut_nohex (
    .clk(clk), .rst_n(rst_n), .din(din), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .lzb_en(lzb_en), .bright(bright),
    .seg(seg_nh), .dp(dp_nh), .an(an_nh), .frame_tick(ft_nh)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         ft;
    logic [6:0]   seg_nh;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;

  // Reference model state: cycles since reset release plus the two frame buffers.
  int         t;
  logic [3:0] m_act[N], m_pend[N];
  logic       m_act_dp[N], m_pend_dp[N];

  function automatic logic [6:0] glyph(input logic [3:0] c, input bit hex);
    case (c)
      4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
      4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
      4'h8: return 7'h00;  4'h9: return 7'h04;
      4'hA: return hex ? 7'h08 : 7'h7F;
      4'hB: return hex ? 7'h60 : 7'h7F;
      4'hC: return hex ? 7'h31 : 7'h7F;
      4'hD: return hex ? 7'h42 : 7'h7F;
      4'hE: return hex ? 7'h30 : 7'h7F;
      default: return hex ? 7'h38 : 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int j = 0; j < N; j++) begin
      m_act[j] = '0; m_pend[j] = '0; m_act_dp[j] = 1'b0; m_pend_dp[j] = 1'b0;
    end
  endtask

  // Predict the pins after the coming clock edge from the current inputs, then advance.
  task automatic step();
    exp_t e;
    int   div, dig;
    bit   allz, blank, wrap;
    div  = t % SD;
    dig  = (t / SD) % N;
    allz = 1'b1;
    for (int j = dig; j < N; j++) if (m_act[j] != 4'd0) allz = 1'b0;
    blank    = !digit_en[dig] || (lzb_en && dig > 0 && allz);
    e.seg    = blank ? 7'h7F : glyph(m_act[dig], 1'b1);
    e.seg_nh = blank ? 7'h7F : glyph(m_act[dig], 1'b0);
    e.dp     = blank ? 1'b1 : !m_act_dp[dig];
    e.an     = (div == 0 || (div / L) > int'(bright)) ? '1 : ~(N'(1) << dig);
    wrap     = (div == SD - 1) && (dig == N - 1);
    e.ft     = wrap;
    q.push_back(e);
    if (wrap) begin
      for (int j = 0; j < N; j++) begin
        m_act[j]    = load ? din[4*j +: 4] : m_pend[j];
        m_act_dp[j] = load ? dp_in[j]      : m_pend_dp[j];
      end
    end
    if (load) begin
      for (int j = 0; j < N; j++) begin
        m_pend[j] = din[4*j +: 4]; m_pend_dp[j] = dp_in[j];
      end
    end
    t++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic load_frame(input logic [4*N-1:0] d, input logic [N-1:0] p);
    din = d; dp_in = p; load = 1'b1;
    run(1);
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_ft"}, 32'(frame_tick), 32'h0);
    check({tag, "_seg_nohex"}, 32'(seg_nh), 32'h7F);
  endtask

  // Monitor: one expected entry per clock edge while the bench is driving.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("seg", 32'(seg), 32'(mon_e.seg));
      check("dp", 32'(dp), 32'(mon_e.dp));
      check("an", 32'(an), 32'(mon_e.an));
      check("frame_tick", 32'(frame_tick), 32'(mon_e.ft));
      check("seg_nohex", 32'(seg_nh), 32'(mon_e.seg_nh));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_blank("reset");
    rst_n = 1'b1;
    model_reset();

    // Basic scan at full brightness.
    bright = 2'd3;
    run(3);
    load_frame(16'h1234, 4'b0000);
    run(70);

    // Load mid-frame: the running frame must not change until the wrap.
    run(10);
    load_frame(16'h5678, 4'b0010);
    run(70);

    // Leading-zero blanking.
    lzb_en = 1'b1;
    load_frame(16'h0070, 4'b1000);
    run(70);

    // Reduced brightness.
    bright = 2'd1;
    run(40);
    bright = 2'd0;
    run(40);

    // Letters, per-digit enable and decimal points.
    lzb_en = 1'b0;
    bright = 2'd3;
    digit_en = 4'b1011;
    load_frame(16'hABCD, 4'b0101);
    run(70);
    digit_en = 4'b1111;
    load_frame(16'hEF90, 4'b1111);
    run(70);

    // Asynchronous reset mid-frame, away from any clock edge.
    run(13);
    #2 rst_n = 1'b0;
    #1 check_blank("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(40);

    // Randomised traffic, including loads that land on frame boundaries.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) begin
        for (int j = 0; j < N; j++)
          din[4*j +: 4] = ($urandom_range(1) == 1) ? 4'd0 : 4'($urandom_range(15));
        dp_in = N'($urandom_range(15));
        load  = 1'b1;
      end
      if ($urandom_range(15) == 0) bright = BW'($urandom_range(3));
      if ($urandom_range(15) == 0) lzb_en = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) digit_en = ($urandom_range(1) == 1) ? 4'hF : N'($urandom_range(15));
      run(1);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
